// File: rtl/lbuffer_pkg.sv
// Shared constants and types for the load buffer: widths, load opcodes,
// memory access sizes, FSM state encoding and the queued entry layout.
package lbuffer_pkg;

    localparam int ADDR_W        = 32;
    localparam int ROB_W         = 4;
    localparam int INST_W        = 6;
    localparam int LBUFFER_DEPTH = 8;

    localparam logic [INST_W-1:0] OP_LB  = 6'd10;
    localparam logic [INST_W-1:0] OP_LH  = 6'd11;
    localparam logic [INST_W-1:0] OP_LW  = 6'd12;
    localparam logic [INST_W-1:0] OP_LBU = 6'd13;
    localparam logic [INST_W-1:0] OP_LHU = 6'd14;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DRAIN
    } lb_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [ROB_W-1:0]  dest;
        logic [INST_W-1:0] opcode;
    } lb_entry_t;

endpackage

// File: rtl/lbuffer_load_extend.sv
// Load data extension: maps a load opcode to its memory access size and
// sign/zero-extends the low-aligned raw memory data to a 32-bit result.
module load_extend
    import lbuffer_pkg::*;
(
    input  logic [INST_W-1:0] opcode,
    input  logic [31:0]       data,
    output logic [31:0]       value,
    output logic [1:0]        size
);

    // Decode the opcode into an access size and the extended result value
    always_comb begin
        value = data;
        size  = SIZE_WORD;
        case (opcode)
            OP_LB: begin
                value = {{24{data[7]}}, data[7:0]};
                size  = SIZE_BYTE;
            end
            OP_LBU: begin
                value = {24'd0, data[7:0]};
                size  = SIZE_BYTE;
            end
            OP_LH: begin
                value = {{16{data[15]}}, data[15:0]};
                size  = SIZE_HALF;
            end
            OP_LHU: begin
                value = {16'd0, data[15:0]};
                size  = SIZE_HALF;
            end
            default: begin
                value = data;
                size  = SIZE_WORD;
            end
        endcase
    end

endmodule

// File: rtl/lbuffer.sv
// Load buffer: queues resolved loads in program order, issues them one at a
// time to the memory controller and broadcasts extended results on the CDB.
// A ROB flush empties the queue; a response already in flight is drained.
module lbuffer
    import lbuffer_pkg::*;
#(
    parameter int DEPTH = LBUFFER_DEPTH
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              addrunit_lbuffer_en_in,
    input  logic [ADDR_W-1:0] addrunit_lbuffer_a_in,
    input  logic [ROB_W-1:0]  addrunit_lbuffer_dest_in,
    input  logic [INST_W-1:0] addrunit_lbuffer_opcode_in,
    output logic              lbuffer_full_out,
    output logic              lbuffer_mem_req_out,
    output logic [ADDR_W-1:0] lbuffer_mem_addr_out,
    output logic [1:0]        lbuffer_mem_size_out,
    input  logic              mem_lbuffer_valid_in,
    input  logic [31:0]       mem_lbuffer_data_in,
    output logic              lbuffer_cdb_en_out,
    output logic [ROB_W-1:0]  lbuffer_cdb_dest_out,
    output logic [31:0]       lbuffer_cdb_value_out,
    input  logic              rob_lbuffer_rst_in
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

    lb_entry_t        entries [DEPTH];
    lb_entry_t        head_entry;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   count;
    lb_state_e        state;
    logic             do_push;
    logic             do_pop;
    logic [31:0]      ext_value;
    logic [1:0]       ext_size;

    assign head_entry       = entries[head];
    assign lbuffer_full_out = (count == FULL_COUNT);

    // A flush discards the incoming entry; a full buffer drops it silently
    assign do_push = addrunit_lbuffer_en_in && !lbuffer_full_out && !rob_lbuffer_rst_in;
    assign do_pop  = (state == ST_WAIT) && mem_lbuffer_valid_in && !rob_lbuffer_rst_in;

    // The head opcode drives both the request size and the result extension
    load_extend u_load_extend (
        .opcode (head_entry.opcode),
        .data   (mem_lbuffer_data_in),
        .value  (ext_value),
        .size   (ext_size)
    );

    // Entry storage is written at the tail; contents need no reset since count gates use
    always_ff @(posedge clk_in) begin
        if (rdy_in && do_push) begin
            entries[tail] <= '{addr:   addrunit_lbuffer_a_in,
                               dest:   addrunit_lbuffer_dest_in,
                               opcode: addrunit_lbuffer_opcode_in};
        end
    end

    // Circular pointers and occupancy; push and pop in one cycle leave count unchanged
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (rdy_in) begin
            if (rob_lbuffer_rst_in) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (do_push) begin
                    tail <= tail + PTR_W'(1);
                end
                if (do_pop) begin
                    head <= head + PTR_W'(1);
                end
                count <= count + {{PTR_W{1'b0}}, do_push} - {{PTR_W{1'b0}}, do_pop};
            end
        end
    end

    // Issue/complete FSM; a flushed in-flight response is absorbed in DRAIN so it never reaches the CDB
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state                 <= ST_IDLE;
            lbuffer_mem_req_out   <= 1'b0;
            lbuffer_mem_addr_out  <= '0;
            lbuffer_mem_size_out  <= 2'd0;
            lbuffer_cdb_en_out    <= 1'b0;
            lbuffer_cdb_dest_out  <= '0;
            lbuffer_cdb_value_out <= '0;
        end else if (rdy_in) begin
            lbuffer_cdb_en_out <= 1'b0;
            if (rob_lbuffer_rst_in) begin
                lbuffer_mem_req_out <= 1'b0;
                case (state)
                    ST_WAIT, ST_DRAIN: state <= mem_lbuffer_valid_in ? ST_IDLE : ST_DRAIN;
                    default:           state <= ST_IDLE;
                endcase
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (count != '0) begin
                            lbuffer_mem_req_out  <= 1'b1;
                            lbuffer_mem_addr_out <= head_entry.addr;
                            lbuffer_mem_size_out <= ext_size;
                            state                <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (mem_lbuffer_valid_in) begin
                            lbuffer_cdb_en_out    <= 1'b1;
                            lbuffer_cdb_dest_out  <= head_entry.dest;
                            lbuffer_cdb_value_out <= ext_value;
                            lbuffer_mem_req_out   <= 1'b0;
                            state                 <= ST_IDLE;
                        end
                    end
                    ST_DRAIN: begin
                        if (mem_lbuffer_valid_in) begin
                            state <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lbuffer.sv
// Testbench for lbuffer: a queue-level reference model of loads in flight,
// a behavioural memory responder, and a scoreboard drained by a CDB monitor.
module tb_lbuffer;
    import lbuffer_pkg::*;

    localparam int DEPTH = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              rdy;
    logic              en;
    logic [ADDR_W-1:0] a_in;
    logic [ROB_W-1:0]  dest_in;
    logic [INST_W-1:0] op_in;
    logic              full;
    logic              req;
    logic [ADDR_W-1:0] mem_addr;
    logic [1:0]        mem_size;
    logic              mem_valid;
    logic [31:0]       mem_data;
    logic              cdb_en;
    logic [ROB_W-1:0]  cdb_dest;
    logic [31:0]       cdb_value;
    logic              flush;

    typedef struct {
        logic [ROB_W-1:0] dest;
        logic [31:0]      value;
    } cdb_t;

    lb_entry_t model_q[$];
    cdb_t      exp_q[$];

    int          checks = 0;
    int          failures = 0;
    bit          outstanding = 0;
    bit          discard = 0;
    int          lat_cnt = 0;
    int          wait_cnt = 0;
    logic [31:0] req_addr_seen = '0;
    bit          rand_mem = 0;
    int          fixed_lat = 3;
    logic [31:0] fixed_data = '0;
    bit          last_rdy = 1'b0;

    logic [INST_W-1:0] ops [5] = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};

    always #5 clk = ~clk;

    lbuffer #(.DEPTH(DEPTH)) dut (
        .clk_in                     (clk),
        .rst_in                     (rst),
        .rdy_in                     (rdy),
        .addrunit_lbuffer_en_in     (en),
        .addrunit_lbuffer_a_in      (a_in),
        .addrunit_lbuffer_dest_in   (dest_in),
        .addrunit_lbuffer_opcode_in (op_in),
        .lbuffer_full_out           (full),
        .lbuffer_mem_req_out        (req),
        .lbuffer_mem_addr_out       (mem_addr),
        .lbuffer_mem_size_out       (mem_size),
        .mem_lbuffer_valid_in       (mem_valid),
        .mem_lbuffer_data_in        (mem_data),
        .lbuffer_cdb_en_out         (cdb_en),
        .lbuffer_cdb_dest_out       (cdb_dest),
        .lbuffer_cdb_value_out      (cdb_value),
        .rob_lbuffer_rst_in         (flush)
    );

    // Architectural result of a load given its opcode and the raw memory word
    function automatic logic [31:0] ext(input logic [INST_W-1:0] op, input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        b = d[7:0];
        h = d[15:0];
        case (op)
            OP_LB:   return 32'(int'($signed(b)));
            OP_LBU:  return 32'(int'(b));
            OP_LH:   return 32'(int'($signed(h)));
            OP_LHU:  return 32'(int'(h));
            default: return d;
        endcase
    endfunction

    // Memory access size implied by a load opcode
    function automatic logic [1:0] size_of(input logic [INST_W-1:0] op);
        if (op == OP_LB || op == OP_LBU) return 2'd0;
        if (op == OP_LH || op == OP_LHU) return 2'd1;
        return 2'd2;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("[TB] FAIL %s got=%h expected=%h at %0t", name, got, want, $time);
        end
    endtask

    // Record whether the most recent clock edge was enabled
    always @(posedge clk) last_rdy = rdy;

    // Monitor: every freshly registered CDB pulse must match the oldest expected result
    always @(negedge clk) begin
        cdb_t e;
        if (!rst && last_rdy && cdb_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL cdb_unexpected got dest=%0d value=%h expected no pulse", cdb_dest, cdb_value);
            end else begin
                e = exp_q.pop_front();
                checkOutput("cdb_dest", 32'(cdb_dest), 32'(e.dest));
                checkOutput("cdb_value", cdb_value, e.value);
            end
        end
    end

    // One cycle: observe the request side, then drive inputs and advance the model
    task automatic applyStimulus(input bit s_en, input logic [31:0] s_a, input logic [ROB_W-1:0] s_dest,
                                 input logic [INST_W-1:0] s_op, input bit s_flush, input bit s_rdy);
        bit        v;
        bit        accept;
        lb_entry_t e;
        @(negedge clk);
        checkOutput("full", 32'(full), 32'(model_q.size() == DEPTH));
        if (!outstanding) begin
            if (model_q.size() == 0) begin
                checkOutput("req_when_empty", 32'(req), 32'd0);
                wait_cnt = 0;
            end else if (req) begin
                checkOutput("req_addr", mem_addr, model_q[0].addr);
                checkOutput("req_size", 32'(mem_size), 32'(size_of(model_q[0].opcode)));
                outstanding   = 1;
                discard       = 0;
                wait_cnt      = 0;
                lat_cnt       = rand_mem ? int'($urandom_range(1, 5)) : fixed_lat;
                req_addr_seen = mem_addr;
            end else if (last_rdy) begin
                wait_cnt++;
                if (wait_cnt == 2) begin
                    checkOutput("req_latency", 32'(req), 32'd1);
                    wait_cnt = 0;
                end
            end
        end else if (discard) begin
            checkOutput("req_drain", 32'(req), 32'd0);
        end else begin
            checkOutput("req_held", 32'(req), 32'd1);
            checkOutput("req_addr_held", mem_addr, req_addr_seen);
        end

        v = 0;
        if (outstanding && s_rdy) begin
            lat_cnt--;
            if (lat_cnt <= 0) v = 1;
        end
        rdy       = s_rdy;
        en        = s_en;
        a_in      = s_a;
        dest_in   = s_dest;
        op_in     = s_op;
        flush     = s_flush;
        mem_valid = v;
        mem_data  = rand_mem ? $urandom : fixed_data;

        if (s_rdy) begin
            if (s_flush) begin
                model_q.delete();
                if (v) begin
                    outstanding = 0;
                    discard     = 0;
                end else if (outstanding) begin
                    discard = 1;
                end
            end else begin
                accept = s_en && (model_q.size() < DEPTH);
                if (v) begin
                    outstanding = 0;
                    if (!discard) begin
                        e = model_q.pop_front();
                        exp_q.push_back('{dest: e.dest, value: ext(e.opcode, mem_data)});
                    end
                    discard = 0;
                end
                if (accept) model_q.push_back('{addr: s_a, dest: s_dest, opcode: s_op});
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, '0, '0, OP_LW, 0, 1);
    endtask

    task automatic load(input logic [31:0] addr, input logic [ROB_W-1:0] d, input logic [INST_W-1:0] op);
        applyStimulus(1, addr, d, op, 0, 1);
    endtask

    initial begin
        logic [31:0] snap_addr;
        logic [1:0]  snap_size;
        logic        snap_req;
        logic        snap_full;
        bit          reached;

        rst = 1; rdy = 1; en = 0; a_in = '0; dest_in = '0; op_in = OP_LW;
        flush = 0; mem_valid = 0; mem_data = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_req", 32'(req), 32'd0);
        checkOutput("rst_full", 32'(full), 32'd0);
        checkOutput("rst_cdb_en", 32'(cdb_en), 32'd0);
        checkOutput("rst_addr", mem_addr, 32'd0);
        checkOutput("rst_size", 32'(mem_size), 32'd0);
        checkOutput("rst_cdb_value", cdb_value, 32'd0);
        rst = 0;

        $display("[TB] basic LW");
        rand_mem = 0; fixed_lat = 3; fixed_data = 32'hDEADBEEF;
        load(32'h100, 4'd3, OP_LW);
        idle(8);

        $display("[TB] sub-word extension");
        fixed_data = 32'h0000_8080;
        load(32'h200, 4'd4, OP_LB);
        load(32'h204, 4'd5, OP_LBU);
        load(32'h208, 4'd6, OP_LH);
        load(32'h20C, 4'd7, OP_LHU);
        idle(30);

        $display("[TB] fill and wrap");
        fixed_lat = 40; fixed_data = 32'h1234_5678;
        for (int i = 0; i < 9; i++) load(32'h300 + 32'(i * 4), 4'(i + 1), OP_LW);
        fixed_lat = 2;
        idle(90);

        $display("[TB] flush in WAIT then DRAIN");
        fixed_lat = 3; fixed_data = 32'hCAFE_F00D;
        load(32'h400, 4'd9, OP_LW);
        idle(2);
        applyStimulus(0, '0, '0, OP_LW, 1, 1);
        load(32'h404, 4'd10, OP_LW);
        idle(12);

        $display("[TB] enqueue with pop, flush with enqueue");
        load(32'h500, 4'd11, OP_LH);
        reached = 0;
        for (int i = 0; i < 20; i++) begin
            if (outstanding && lat_cnt == 1) begin
                reached = 1;
                break;
            end
            idle(1);
        end
        checkOutput("pop_window_reached", 32'(reached), 32'd1);
        load(32'h504, 4'd12, OP_LBU);
        idle(12);
        applyStimulus(1, 32'h600, 4'd13, OP_LW, 1, 1);
        idle(4);

        $display("[TB] rdy stall mid-WAIT");
        fixed_lat = 6; fixed_data = 32'h8765_4321;
        load(32'h700, 4'd14, OP_LB);
        idle(3);
        applyStimulus(0, '0, '0, OP_LW, 0, 0);
        snap_req = req; snap_addr = mem_addr; snap_size = mem_size; snap_full = full;
        for (int i = 0; i < 4; i++) begin
            if (i < 3) applyStimulus(1, 32'h7F0, 4'd15, OP_LW, 0, 0);
            else applyStimulus(0, '0, '0, OP_LW, 0, 1);
            checkOutput("stall_req", 32'(req), 32'(snap_req));
            checkOutput("stall_addr", mem_addr, snap_addr);
            checkOutput("stall_size", 32'(mem_size), 32'(snap_size));
            checkOutput("stall_full", 32'(full), 32'(snap_full));
            checkOutput("stall_cdb_en", 32'(cdb_en), 32'd0);
        end
        idle(12);

        $display("[TB] randomized traffic");
        rand_mem = 1;
        for (int i = 0; i < 1500; i++) begin
            applyStimulus(($urandom_range(0, 1) == 1), $urandom, ROB_W'($urandom_range(1, 15)),
                          ops[$urandom_range(0, 4)], ($urandom_range(0, 59) == 0),
                          ($urandom_range(0, 9) != 0));
        end

        reached = 0;
        for (int i = 0; i < 300; i++) begin
            if (model_q.size() == 0 && !outstanding && exp_q.size() == 0) begin
                reached = 1;
                break;
            end
            idle(1);
        end
        checkOutput("drain_complete", 32'(reached), 32'd1);
        idle(3);
        checkOutput("cdb_missing", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog so the run always terminates
    initial begin
        #500000;
        $display("[TB] FAIL watchdog got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
